lm_sm_sequencer: RTL

Multi-cycle controller for the LM/SM (load/store multiple) instructions of the pipelined RISC core. It sits at the ID stage. It captures an LM or SM instruction and holds fetch. It then issues one single-register micro-op per cycle, lowest register first, into the register-read/execute/memory datapath, so the forwarding and hazard logic only ever sees one register transfer per pipeline slot. Pipeline stalls from downstream hazard logic and flushes from branch resolution are both honoured.

---
 rtl/risc_isa_pkg.sv | 44 ++++
 rtl/lowest_set_bit8.sv | 20 ++
 rtl/lm_sm_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/risc_isa_pkg.sv
// ISA constants shared by the LM/SM sequencer and the forwarding units: major and 6-bit opcodes
// plus instruction field positions.
package risc_isa_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  localparam logic [5:0] OP6_ADD = 6'b000000;
  localparam logic [5:0] OP6_ADZ = 6'b000001;
  localparam logic [5:0] OP6_ADC = 6'b000010;
  localparam logic [5:0] OP6_ADI = 6'b000100;
  localparam logic [5:0] OP6_NDU = 6'b001000;
  localparam logic [5:0] OP6_NDZ = 6'b001001;
  localparam logic [5:0] OP6_NDC = 6'b001010;
  localparam logic [5:0] OP6_LHI = 6'b001100;
  localparam logic [5:0] OP6_LW  = 6'b010000;
  localparam logic [5:0] OP6_SW  = 6'b010100;
  localparam logic [5:0] OP6_LM  = 6'b011000;
  localparam logic [5:0] OP6_SM  = 6'b011100;
  localparam logic [5:0] OP6_JAL = 6'b100000;
  localparam logic [5:0] OP6_JLR = 6'b100100;
  localparam logic [5:0] OP6_BEQ = 6'b110000;

  localparam int unsigned OpcMsb  = 15;
  localparam int unsigned OpcLsb  = 12;
  localparam int unsigned RaMsb   = 11;
  localparam int unsigned RaLsb   = 9;
  localparam int unsigned ListMsb = 7;
  localparam int unsigned ListLsb = 0;

  function automatic logic is_lm_sm(input logic [3:0] opc);
    return (opc == OP_LM) || (opc == OP_SM);
  endfunction

endpackage

// File: rtl/lowest_set_bit8.sv
// Combinational 8-bit priority encoder favouring the lowest set bit.
module lowest_set_bit8 (
  input  logic [7:0] data_i,
  output logic [2:0] index_o,
  output logic [7:0] one_hot_o,
  output logic       single_o
);

  always_comb begin
    index_o = 3'd0;
    // Descending scan so the lowest set bit is the last to write.
    for (int i = 7; i >= 0; i--) begin
      if (data_i[i]) index_o = 3'(i);
    end
  end

  assign one_hot_o = data_i & (~data_i + 8'd1);
  assign single_o  = (data_i != 8'd0) && ((data_i & (data_i - 8'd1)) == 8'd0);

endmodule

// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: holds fetch and issues one single-register micro-op per cycle,
// lowest register first, honouring downstream stalls and branch flushes.
module lm_sm_sequencer
  import risc_isa_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic        stall_in,
  input  logic        flush,
  output logic        fetch_hold,
  output logic        id_ack,
  output logic        uop_valid,
  output logic [5:0]  uop_op,
  output logic [2:0]  uop_regA,
  output logic [2:0]  uop_regC,
  output logic [2:0]  uop_offset,
  output logic        uop_first,
  output logic        uop_last
);

  localparam logic StIdle = 1'b0;
  localparam logic StSeq  = 1'b1;

  logic       state_q, state_d;
  logic [7:0] list_q, list_d;
  logic [2:0] base_q, base_d;
  logic [3:0] op_q, op_d;
  logic [2:0] cnt_q, cnt_d;

  logic [3:0] id_opc;
  logic [2:0] id_ra;
  logic [7:0] id_list;
  logic       unused_id_bit8;
  logic       start;
  logic       issue;

  logic [2:0] lsb_index;
  logic [7:0] lsb_one_hot;
  logic       lsb_single;

  assign id_opc         = id_instr[OpcMsb:OpcLsb];
  assign id_ra          = id_instr[RaMsb:RaLsb];
  assign id_list        = id_instr[ListMsb:ListLsb];
  assign unused_id_bit8 = id_instr[8];
  assign start          = id_valid && is_lm_sm(id_opc) && !flush;

  lowest_set_bit8 u_lsb (
    .data_i    (list_q),
    .index_o   (lsb_index),
    .one_hot_o (lsb_one_hot),
    .single_o  (lsb_single)
  );

  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    base_d     = base_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    fetch_hold = 1'b0;
    id_ack     = 1'b0;
    uop_valid  = 1'b0;
    uop_op     = 6'd0;
    uop_regA   = 3'd0;
    uop_regC   = 3'd0;
    uop_offset = 3'd0;
    uop_first  = 1'b0;
    uop_last   = 1'b0;

    if (state_q == StSeq) begin
      uop_valid  = !flush;
      uop_op     = {op_q, 2'b00};
      uop_regA   = base_q;
      uop_regC   = lsb_index;
      uop_offset = cnt_q;
      uop_first  = (cnt_q == 3'd0);
      uop_last   = lsb_single;
      issue      = uop_valid && !stall_in;
      if (flush) begin
        state_d = StIdle;
        list_d  = 8'd0;
      end else begin
        fetch_hold = !(issue && lsb_single);
        if (issue) begin
          list_d = list_q & ~lsb_one_hot;
          if (lsb_single) begin
            id_ack  = 1'b1;
            state_d = StIdle;
          end else begin
            // Count stops at the last micro-op so 8 transfers never wrap.
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
    end else if (start) begin
      if (id_list != 8'd0) begin
        fetch_hold = 1'b1;
        list_d     = id_list;
        base_d     = id_ra;
        op_d       = id_opc;
        cnt_d      = 3'd0;
        state_d    = StSeq;
      end else begin
        id_ack = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      list_q  <= 8'd0;
      base_q  <= 3'd0;
      op_q    <= 4'd0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      base_q  <= base_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
